// File: rtl/systolic4x4_serial_io.sv
// ---------------------------------------------------------------------------
// systolic4x4_serial_io
//   4x4 output-stationary systolic matrix-multiply tile with bit-serial I/O.
//   A (ROWS x K) and B (K x COLS) signed tiles arrive over two independent
//   serial links. C = A x B is accumulated at ACCW bits and streamed out
//   over a third serial link.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   start                  arms one multiply (IDLE or DONE only)
//   A_in_serial_data/clk   A bit and bit-slot enable
//   A_in_frame_sync        A element start marker (slot carries no data)
//   B_in_serial_*          same for B
//   C_out_serial_data      C bit, changes only on enabled C slots
//   C_out_serial_clk       C bit-slot enable from the receiver
//   C_out_frame_sync       high for the single sync slot preceding the data
//   done                   high once the whole result has been transmitted
//
// Output slot timing: the value driven after an enabled C edge belongs to
// that slot. One sync slot, then 512 data slots (C[0][0]..C[3][3], LSB
// first). The enabled slot after the last data bit returns the data line to
// 0 and raises done, so the last bit is held for a full slot.
// ---------------------------------------------------------------------------

module systolic_serial_rx #(
  parameter int W = 8,
  parameter int N = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_idx,
  input  logic                sdata,
  input  logic                sclk,
  input  logic                fsync,
  output logic                full,
  output logic signed [W-1:0] mem [N]
);
  localparam int CW = $clog2(W);
  localparam int IW = $clog2(N + 1);
  localparam int IL = $clog2(N);
  localparam logic [CW-1:0] BIT_LAST = CW'(W - 1);
  localparam logic [IW-1:0] IDX_FULL = IW'(N);

  logic [CW-1:0] bitc;
  logic [W-2:0]  sh;
  logic [IW-1:0] idx;
  logic          wr;

  assign full = (idx == IDX_FULL);
  // Last bit of an element; elements past the end of the tile are dropped.
  assign wr   = sclk && !fsync && (bitc == BIT_LAST) && !full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitc <= '0;
      sh   <= '0;
      idx  <= '0;
    end else begin
      if (sclk) begin
        if (fsync) begin
          bitc <= '0;
        end else begin
          sh   <= {sdata, sh[W-2:1]};
          bitc <= (bitc == BIT_LAST) ? '0 : bitc + 1'b1;
        end
      end
      if (clr_idx)
        idx <= '0;
      else if (wr)
        idx <= idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem[idx[IL-1:0]] <= {sdata, sh};
  end
endmodule

module systolic4x4_serial_io #(
  parameter int AW   = 8,
  parameter int BW   = 8,
  parameter int ACCW = 32,
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int K    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic A_in_serial_data,
  input  logic A_in_serial_clk,
  input  logic A_in_frame_sync,
  input  logic B_in_serial_data,
  input  logic B_in_serial_clk,
  input  logic B_in_frame_sync,
  output logic C_out_serial_data,
  input  logic C_out_serial_clk,
  output logic C_out_frame_sync,
  output logic done
);
  localparam int NA   = ROWS * K;
  localparam int NB   = K * COLS;
  localparam int NC   = ROWS * COLS;
  localparam int NCYC = K + ROWS + COLS - 1;
  localparam int TW   = $clog2(NCYC + 1);
  localparam int EW   = $clog2(NC);
  localparam int PW   = $clog2(ACCW);
  localparam logic [TW-1:0] T_LAST  = TW'(NCYC - 1);
  localparam logic [EW-1:0] E_LAST  = EW'(NC - 1);
  localparam logic [PW-1:0] BP_LAST = PW'(ACCW - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_COMP = 3'd2;
  localparam logic [2:0] S_SYNC = 3'd3;
  localparam logic [2:0] S_SEND = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  function automatic logic signed [ACCW-1:0] mac(
    input logic signed [ACCW-1:0] acc,
    input logic signed [AW-1:0]   a,
    input logic signed [BW-1:0]   b
  );
    logic signed [AW+BW-1:0] p;
    p = a * b;
    return acc + ACCW'(p);
  endfunction

  logic [2:0]    state;
  logic [TW-1:0] t;
  logic [EW-1:0] elem;
  logic [PW-1:0] bitpos;
  logic          sent_all;
  logic          a_full, b_full, leave_wait;

  logic signed [AW-1:0]   a_mem  [NA];
  logic signed [BW-1:0]   b_mem  [NB];
  logic signed [AW-1:0]   a_grid [ROWS][COLS];
  logic signed [BW-1:0]   b_grid [ROWS][COLS];
  logic signed [ACCW-1:0] acc_flat [NC];
  logic signed [ACCW-1:0] cur_word;

  // Both tiles present: release the load buffers for the next tile now.
  // Operands are read from the buffers only up to cycle r+k, which always
  // precedes the earliest time a new element could overwrite that entry.
  assign leave_wait = (state == S_WAIT) && a_full && b_full;

  systolic_serial_rx #(.W(AW), .N(NA)) u_rx_a (
    .clk(clk), .rst_n(rst_n), .clr_idx(leave_wait),
    .sdata(A_in_serial_data), .sclk(A_in_serial_clk), .fsync(A_in_frame_sync),
    .full(a_full), .mem(a_mem)
  );

  systolic_serial_rx #(.W(BW), .N(NB)) u_rx_b (
    .clk(clk), .rst_n(rst_n), .clr_idx(leave_wait),
    .sdata(B_in_serial_data), .sclk(B_in_serial_clk), .fsync(B_in_frame_sync),
    .full(b_full), .mem(b_mem)
  );

  // PE grid: operands enter skewed at the west/north edges and move one PE
  // per cycle, so PE(r,c) sees A[r][k] and B[k][c] together at t = r+c+k.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic signed [AW-1:0]   a_in, a_q;
      logic signed [BW-1:0]   b_in, b_q;
      logic signed [ACCW-1:0] acc_q;

      if (c == 0) begin : g_afeed
        always_comb begin
          a_in = '0;
          for (int k = 0; k < K; k++)
            if (t == TW'(r + k)) a_in = a_mem[r*K + k];
        end
      end else begin : g_apass
        assign a_in = a_grid[r][c-1];
      end

      if (r == 0) begin : g_bfeed
        always_comb begin
          b_in = '0;
          for (int k = 0; k < K; k++)
            if (t == TW'(c + k)) b_in = b_mem[k*COLS + c];
        end
      end else begin : g_bpass
        assign b_in = b_grid[r-1][c];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else if (leave_wait) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else if (state == S_COMP) begin
          a_q   <= a_in;
          b_q   <= b_in;
          acc_q <= mac(acc_q, a_in, b_in);
        end
      end

      assign a_grid[r][c]       = a_q;
      assign b_grid[r][c]       = b_q;
      assign acc_flat[r*COLS+c] = acc_q;
    end
  end

  assign cur_word = acc_flat[elem];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      t                 <= '0;
      elem              <= '0;
      bitpos            <= '0;
      sent_all          <= 1'b0;
      done              <= 1'b0;
      C_out_frame_sync  <= 1'b0;
      C_out_serial_data <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            done  <= 1'b0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (a_full && b_full) begin
            t     <= '0;
            state <= S_COMP;
          end
        end
        S_COMP: begin
          if (t == T_LAST)
            state <= S_SYNC;
          else
            t <= t + 1'b1;
        end
        S_SYNC: begin
          if (C_out_serial_clk) begin
            C_out_frame_sync  <= 1'b1;
            C_out_serial_data <= 1'b0;
            elem              <= '0;
            bitpos            <= '0;
            sent_all          <= 1'b0;
            state             <= S_SEND;
          end
        end
        S_SEND: begin
          if (C_out_serial_clk) begin
            C_out_frame_sync <= 1'b0;
            if (sent_all) begin
              C_out_serial_data <= 1'b0;
              done              <= 1'b1;
              state             <= S_DONE;
            end else begin
              C_out_serial_data <= cur_word[bitpos];
              bitpos            <= bitpos + 1'b1;
              if (bitpos == BP_LAST) begin
                elem <= elem + 1'b1;
                if (elem == E_LAST) sent_all <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          if (start) begin
            done  <= 1'b0;
            state <= S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic4x4_serial_io.sv
module tb_systolic4x4_serial_io;
  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic A_in_serial_data, A_in_serial_clk, A_in_frame_sync;
  logic B_in_serial_data, B_in_serial_clk, B_in_frame_sync;
  logic C_out_serial_data, C_out_serial_clk, C_out_frame_sync;
  logic done;

  int checks = 0;
  int errors = 0;

  int a_tile [16];
  int b_tile [16];
  int exp_c  [16];

  systolic4x4_serial_io dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .A_in_serial_data(A_in_serial_data), .A_in_serial_clk(A_in_serial_clk),
    .A_in_frame_sync(A_in_frame_sync),
    .B_in_serial_data(B_in_serial_data), .B_in_serial_clk(B_in_serial_clk),
    .B_in_frame_sync(B_in_frame_sync),
    .C_out_serial_data(C_out_serial_data), .C_out_serial_clk(C_out_serial_clk),
    .C_out_frame_sync(C_out_frame_sync), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic a_slot(input logic fs, input logic d);
    @(negedge clk);
    A_in_serial_clk = 1'b1; A_in_frame_sync = fs; A_in_serial_data = d;
  endtask

  task automatic b_slot(input logic fs, input logic d);
    @(negedge clk);
    B_in_serial_clk = 1'b1; B_in_frame_sync = fs; B_in_serial_data = d;
  endtask

  task automatic links_off();
    @(negedge clk);
    A_in_serial_clk = 1'b0; A_in_frame_sync = 1'b0; A_in_serial_data = 1'b0;
    B_in_serial_clk = 1'b0; B_in_frame_sync = 1'b0; B_in_serial_data = 1'b0;
  endtask

  // glitch_after >= 0: after that element, 3 stray bits then a sync slot.
  task automatic load_a(input int first, input int last, input bit sync, input int glitch_after);
    logic [7:0] v;
    if (sync) a_slot(1'b1, 1'b0);
    for (int i = first; i <= last; i++) begin
      v = 8'(a_tile[i]);
      for (int b = 0; b < 8; b++) a_slot(1'b0, v[b]);
      if (i == glitch_after) begin
        for (int g = 0; g < 3; g++) a_slot(1'b0, 1'b1);
        a_slot(1'b1, 1'b0);
      end
    end
    links_off();
  endtask

  task automatic load_b();
    logic [7:0] v;
    b_slot(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      v = 8'(b_tile[i]);
      for (int b = 0; b < 8; b++) b_slot(1'b0, v[b]);
    end
    links_off();
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Receives the C stream and compares it with exp_c. stall_at / abort_at
  // name a data-bit index (or -1) where the enable is dropped for 20 cycles
  // or reset is asserted.
  task automatic recv_c(input int stall_at, input int abort_at);
    int cyc = 0;
    int fs_bad = 0;
    logic got_sync = 1'b0;
    logic hold, changed;
    logic [31:0] word;
    while (!got_sync && cyc < 3000) begin
      @(negedge clk); C_out_serial_clk = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (C_out_frame_sync) got_sync = 1'b1;
    end
    chk("sync_seen", 32'(got_sync), 32'd1);
    if (!got_sync) return;
    chk("sync_data", 32'(C_out_serial_data), 32'd0);
    for (int e = 0; e < 16; e++) begin
      word = '0;
      for (int b = 0; b < 32; b++) begin
        if (e*32 + b == abort_at) begin
          @(negedge clk); rst_n = 1'b0;
          #1;
          chk("abort_data", 32'(C_out_serial_data), 32'd0);
          chk("abort_sync", 32'(C_out_frame_sync), 32'd0);
          chk("abort_done", 32'(done), 32'd0);
          return;
        end
        if (e*32 + b == stall_at) begin
          @(negedge clk); C_out_serial_clk = 1'b0;
          hold = C_out_serial_data;
          changed = 1'b0;
          repeat (20) begin
            @(posedge clk); #1;
            if (C_out_serial_data !== hold || done !== 1'b0) changed = 1'b1;
          end
          chk("stall_frozen", 32'(changed), 32'd0);
        end
        @(negedge clk); C_out_serial_clk = 1'b1;
        @(posedge clk); #1;
        word[b] = C_out_serial_data;
        if (C_out_frame_sync) fs_bad++;
      end
      chk($sformatf("c%0d", e), word, 32'(exp_c[e]));
    end
    chk("fs_in_stream", 32'(fs_bad), 32'd0);
    chk("done_before_end", 32'(done), 32'd0);
    @(negedge clk); C_out_serial_clk = 1'b1;
    @(posedge clk); #1;
    chk("done_set", 32'(done), 32'd1);
    chk("data_idle", 32'(C_out_serial_data), 32'd0);
    @(negedge clk); C_out_serial_clk = 1'b0;
  endtask

  task automatic set_spec_tiles();
    a_tile = '{1, 2, 3, 4, 0, -1, 2, 3, 2, 2, -1, 1, 4, 0, 1, -2};
    b_tile = '{1, 0, -1, 2, 2, 1, 0, 0, -1, 2, 1, 1, 3, -1, 2, 0};
    exp_c  = '{14, 4, 10, 5, 5, 0, 8, 2, 10, -1, -1, 3, -3, 4, -7, 9};
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; start = 1'b0; C_out_serial_clk = 1'b0;
    A_in_serial_data = 1'b0; A_in_serial_clk = 1'b0; A_in_frame_sync = 1'b0;
    B_in_serial_data = 1'b0; B_in_serial_clk = 1'b0; B_in_frame_sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", 32'(C_out_serial_data), 32'd0);
    chk("rst_sync", 32'(C_out_frame_sync), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Functional tile
    set_spec_tiles();
    load_a(0, 15, 1'b1, -1);
    load_b();
    pulse_start();
    recv_c(-1, -1);

    // Start from DONE; start before any data; WAIT holds with 15 A elements
    pulse_start();
    chk("start_clears_done", 32'(done), 32'd0);
    for (int i = 0; i < 16; i++) begin
      a_tile[i] = -128; b_tile[i] = -128; exp_c[i] = 65536;
    end
    load_b();
    load_a(0, 14, 1'b1, -1);
    seen = 1'b0;
    @(negedge clk); C_out_serial_clk = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      if (C_out_frame_sync) seen = 1'b1;
    end
    @(negedge clk); C_out_serial_clk = 1'b0;
    chk("wait15_sync", 32'(seen), 32'd0);
    chk("wait15_done", 32'(done), 32'd0);
    load_a(15, 15, 1'b0, -1);
    recv_c(-1, -1);

    // Positive x negative extreme with a receiver stall mid-stream
    for (int i = 0; i < 16; i++) begin
      a_tile[i] = 127; b_tile[i] = -128; exp_c[i] = -65024;
    end
    load_a(0, 15, 1'b1, -1);
    load_b();
    pulse_start();
    recv_c(100, -1);

    // Reset during SEND, then a clean restart with a framing glitch in A
    set_spec_tiles();
    load_a(0, 15, 1'b1, -1);
    load_b();
    pulse_start();
    recv_c(-1, 100);
    @(negedge clk); C_out_serial_clk = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    a_tile = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    exp_c  = b_tile;
    load_a(0, 15, 1'b1, 0);
    load_b();
    pulse_start();
    recv_c(-1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
